seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller. It is the successor of the fixed 6-digit scan driver.
- Stores one hex nibble and one decimal point per digit. Each digit is written independently with a per-digit write mask.
- Time-multiplexes the digits onto a shared segment bus and a binary digit-select bus.
- New features: PWM brightness, per-digit blanking, per-digit blinking, selectable segment polarity, and a frame-done pulse.
- Sits between the application (temperature/value formatting) and the board's segment/select pins.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_dec7.sv | 16 +
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and the nibble-to-segment decode for the 7-segment scan controller.
package seg_pkg;

    localparam logic [7:0] SEG_OFF_AL = 8'hFF;
    localparam logic [7:0] SEG_OFF_AH = 8'h00;

    // Active-low codes for hex digits 0..F, bit7 = dp, bits6..0 = g..a.
    localparam logic [7:0] SEG_CODE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] seg_decode(input logic [3:0] nibble,
                                              input logic       dp,
                                              input logic       active_low);
        logic [7:0] code;
        code = SEG_CODE[nibble];
        if (dp) begin
            code[7] = 1'b0;
        end
        return active_low ? code : ~code;
    endfunction

endpackage

// File: rtl/seg_dec7.sv
// Combinational nibble + decimal point to 8-bit segment pattern.
module seg_dec7
    import seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = seg_decode(nibble, dp, ACTIVE_LOW);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with PWM brightness, blanking,
// blinking, selectable polarity and a frame-done pulse.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIG    = 6,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned SCAN_CNT   = 50000,
    parameter int unsigned BLINK_FRM  = 25,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 disp_en,
    input  logic [NUM_DIG*4-1:0] din,
    input  logic [NUM_DIG-1:0]   dp_in,
    input  logic [NUM_DIG-1:0]   din_vld,
    input  logic [NUM_DIG-1:0]   blank_mask,
    input  logic [NUM_DIG-1:0]   blink_mask,
    input  logic [2:0]           brightness,
    output logic [SEL_W-1:0]     seg_sel,
    output logic [7:0]           segment,
    output logic                 frame_done
);

    localparam int unsigned CNT0_W    = $clog2(SCAN_CNT);
    localparam int unsigned THR_W     = CNT0_W + 1;
    localparam int unsigned FRM_W     = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;
    localparam int unsigned SLOT_STEP = SCAN_CNT / 8;
    localparam logic [7:0]       SEG_OFF  = ACTIVE_LOW ? SEG_OFF_AL : SEG_OFF_AH;
    localparam logic [SEL_W-1:0] SEL_NONE = '1;

    logic [NUM_DIG-1:0][3:0] dig_q, dig_d;
    logic [NUM_DIG-1:0]      dp_q, dp_d;
    logic [CNT0_W-1:0]       cnt0_q, cnt0_d;
    logic [SEL_W-1:0]        cnt1_q, cnt1_d;
    logic [FRM_W-1:0]        frm_q, frm_d;
    logic                    phase_q, phase_d;
    logic [SEL_W-1:0]        seg_sel_q, seg_sel_d;
    logic [7:0]              segment_q, segment_d;
    logic                    frame_done_q, frame_done_d;

    logic                    cnt0_wrap_c, cnt1_wrap_c, frm_wrap_c;
    logic [THR_W-1:0]        thr_c;
    logic                    lit_c;
    logic [7:0]              dec_seg_c;

    // Digit storage: per-digit masked writes, independent of disp_en.
    always_comb begin
        dig_d = dig_q;
        dp_d  = dp_q;
        for (int k = 0; k < int'(NUM_DIG); k++) begin
            if (din_vld[k]) begin
                dig_d[k] = din[4*k +: 4];
                dp_d[k]  = dp_in[k];
            end
        end
    end

    // Slot / digit / frame counters; all clear while the display is disabled.
    always_comb begin
        cnt0_wrap_c = (cnt0_q == CNT0_W'(SCAN_CNT - 1));
        cnt1_wrap_c = (cnt1_q == SEL_W'(NUM_DIG - 1));
        frm_wrap_c  = (frm_q == FRM_W'(BLINK_FRM - 1));
        cnt0_d      = '0;
        cnt1_d      = '0;
        frm_d       = '0;
        phase_d     = 1'b0;
        if (disp_en) begin
            cnt0_d  = cnt0_wrap_c ? '0 : cnt0_q + CNT0_W'(1);
            cnt1_d  = cnt1_q;
            frm_d   = frm_q;
            phase_d = phase_q;
            if (cnt0_wrap_c) begin
                cnt1_d = cnt1_wrap_c ? '0 : cnt1_q + SEL_W'(1);
                if (cnt1_wrap_c) begin
                    frm_d = frm_wrap_c ? '0 : frm_q + FRM_W'(1);
                    if (frm_wrap_c) begin
                        phase_d = ~phase_q;
                    end
                end
            end
        end
    end

    seg_dec7 #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .nibble (dig_q[cnt1_q]),
        .dp     (dp_q[cnt1_q]),
        .seg_c  (dec_seg_c)
    );

    // Output selection: the digit is never selected while its segments are dark.
    always_comb begin
        thr_c        = THR_W'({1'b0, brightness} + 4'd1) * THR_W'(SLOT_STEP);
        lit_c        = disp_en && !blank_mask[cnt1_q]
                       && !(blink_mask[cnt1_q] && phase_q)
                       && ({1'b0, cnt0_q} < thr_c);
        seg_sel_d    = lit_c ? cnt1_q : SEL_NONE;
        segment_d    = lit_c ? dec_seg_c : SEG_OFF;
        frame_done_d = disp_en && cnt0_wrap_c && cnt1_wrap_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q        <= '0;
            dp_q         <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            frm_q        <= '0;
            phase_q      <= 1'b0;
            seg_sel_q    <= SEL_NONE;
            segment_q    <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            dig_q        <= dig_d;
            dp_q         <= dp_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            frm_q        <= frm_d;
            phase_q      <= phase_d;
            seg_sel_q    <= seg_sel_d;
            segment_q    <= segment_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_sel    = seg_sel_q;
    assign segment    = segment_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: decode vector table, directed scan sequences and
// randomized traffic against a cycle-count based reference model.
module tb_seg_scan_ctrl;

    localparam int ND    = 6;
    localparam int SLOT  = 16;
    localparam int FRAME = ND * SLOT;
    localparam int BFRM  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_en;
    logic [23:0]   din;
    logic [5:0]    dp_in;
    logic [5:0]    din_vld;
    logic [5:0]    blank_mask;
    logic [5:0]    blink_mask;
    logic [2:0]    brightness;
    logic [2:0]    seg_sel;
    logic [7:0]    segment;
    logic          frame_done;

    seg_scan_ctrl #(
        .NUM_DIG    (ND),
        .SEL_W      (3),
        .SCAN_CNT   (SLOT),
        .BLINK_FRM  (BFRM),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_en    (disp_en),
        .din        (din),
        .dp_in      (dp_in),
        .din_vld    (din_vld),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .seg_sel    (seg_sel),
        .segment    (segment),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: n = enabled cycles since the scan (re)started.
    int        n;
    logic [3:0] mdig [ND];
    logic       mdp  [ND];
    logic [7:0] tbl  [16];

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [7:0] exp_seg;
    } vec_t;
    vec_t vt [20];

    function automatic logic [7:0] model_seg(input logic [3:0] nib, input logic dp);
        logic [7:0] c;
        c = tbl[nib];
        if (dp) c[7] = 1'b0;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int k = 0; k < ND; k++) begin
            mdig[k] = 4'h0;
            mdp[k]  = 1'b0;
        end
    endtask

    // One clock: predict from pre-edge state, advance the model, compare after the edge.
    task automatic step();
        int c0, c1, ph;
        logic lit, efd;
        logic [2:0] es;
        logic [7:0] eseg;
        c0   = n % SLOT;
        c1   = (n / SLOT) % ND;
        ph   = (n / (FRAME * BFRM)) % 2;
        lit  = disp_en && !blank_mask[c1] && !(blink_mask[c1] && ph == 1)
               && (c0 < (int'(brightness) + 1) * (SLOT / 8));
        es   = lit ? 3'(c1) : 3'b111;
        eseg = lit ? model_seg(mdig[c1], mdp[c1]) : 8'hFF;
        efd  = disp_en && c0 == SLOT - 1 && c1 == ND - 1;
        for (int k = 0; k < ND; k++) begin
            if (din_vld[k]) begin
                mdig[k] = din[4*k +: 4];
                mdp[k]  = dp_in[k];
            end
        end
        n = disp_en ? n + 1 : 0;
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if ({seg_sel, segment, frame_done} !== {es, eseg, efd}) begin
            errors++;
            $display("FAIL model cycle %0d: sel/seg/fd got %h/%h/%b expected %h/%h/%b",
                     cyc, seg_sel, segment, frame_done, es, eseg, efd);
        end
    endtask

    task automatic write_all(input logic [23:0] d, input logic [5:0] p);
        din_vld = 6'h3F;
        din     = d;
        dp_in   = p;
        step();
        din_vld = 6'h00;
    endtask

    task automatic restart();
        disp_en = 1'b0;
        step();
        disp_en = 1'b1;
    endtask

    int fd_cnt, fd_first, fd_last, lit_cnt, d0_cnt, d1_cnt;

    initial begin
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        vt = '{
            '{4'h0, 1'b0, 8'hC0}, '{4'h1, 1'b0, 8'hF9}, '{4'h2, 1'b0, 8'hA4},
            '{4'h3, 1'b0, 8'hB0}, '{4'h4, 1'b0, 8'h99}, '{4'h5, 1'b0, 8'h92},
            '{4'h6, 1'b0, 8'h82}, '{4'h7, 1'b0, 8'hF8}, '{4'h8, 1'b0, 8'h80},
            '{4'h9, 1'b0, 8'h90}, '{4'hA, 1'b0, 8'h88}, '{4'hB, 1'b0, 8'h83},
            '{4'hC, 1'b0, 8'hC6}, '{4'hD, 1'b0, 8'hA1}, '{4'hE, 1'b0, 8'h86},
            '{4'hF, 1'b0, 8'h8E}, '{4'h8, 1'b1, 8'h00}, '{4'h0, 1'b1, 8'h40},
            '{4'hF, 1'b1, 8'h0E}, '{4'hA, 1'b1, 8'h08}
        };

        rst_n = 1'b0; disp_en = 1'b0; din = '0; dp_in = '0; din_vld = '0;
        blank_mask = '0; blink_mask = '0; brightness = 3'd7;
        model_reset();
        #12;
        chk("reset_sel", 32'(seg_sel), 32'h7);
        chk("reset_seg", 32'(segment), 32'hFF);
        chk("reset_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with display disabled: outputs must not move.
        for (int i = 0; i < 50; i++) step();

        // Decode table: write all digits, restart, first lit output is digit 0.
        foreach (vt[i]) begin
            disp_en = 1'b0;
            write_all({6{vt[i].nib}}, {6{vt[i].dp}});
            disp_en = 1'b1;
            step();
            chk("dec_sel", 32'(seg_sel), 32'h0);
            chk($sformatf("dec_seg_%h_%b", vt[i].nib, vt[i].dp), 32'(segment), 32'(vt[i].exp_seg));
        end

        // Full brightness scan of 012345 over two frames.
        write_all(24'h012345, 6'h00);
        restart();
        fd_cnt = 0; fd_first = -1; fd_last = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (frame_done) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = i;
                fd_last = i;
            end
        end
        chk("fd_count", 32'(fd_cnt), 32'd2);
        chk("fd_first", 32'(fd_first), 32'(FRAME - 1));
        chk("fd_period", 32'(fd_last - fd_first), 32'(FRAME));

        // Minimum brightness: 2 lit cycles per slot.
        brightness = 3'd0;
        restart();
        lit_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (seg_sel != 3'h7) lit_cnt++;
        end
        chk("dim_lit_cycles", 32'(lit_cnt), 32'(2 * ND));

        // Blink digit 0, blank digit 1, over four frames.
        brightness = 3'd7; blink_mask = 6'b000001; blank_mask = 6'b000010;
        restart();
        d0_cnt = 0; d1_cnt = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step();
            if (seg_sel == 3'd0) d0_cnt++;
            if (seg_sel == 3'd1) d1_cnt++;
        end
        chk("blink_d0_lit", 32'(d0_cnt), 32'(2 * SLOT));
        chk("blank_d1_lit", 32'(d1_cnt), 32'd0);
        blink_mask = '0; blank_mask = '0;

        // Mid-slot write to the digit being shown.
        restart();
        for (int i = 0; i < 2 * SLOT + 5; i++) step();
        din_vld = 6'b000100; din = 24'h000A00; dp_in = 6'b000100;
        step();
        din_vld = '0; din = '0; dp_in = '0;
        step();
        chk("midwrite_sel", 32'(seg_sel), 32'h2);
        chk("midwrite_seg", 32'(segment), 32'h08);

        // Drop enable at cnt1=3, cnt0=7, then re-enable.
        restart();
        for (int i = 0; i < 3 * SLOT + 7; i++) step();
        disp_en = 1'b0;
        step();
        chk("drop_sel", 32'(seg_sel), 32'h7);
        chk("drop_seg", 32'(segment), 32'hFF);
        disp_en = 1'b1;
        step();
        chk("reen_sel", 32'(seg_sel), 32'h0);
        chk("reen_seg", 32'(segment), 32'h92);
        for (int i = 0; i < 2 * SLOT; i++) step();
        chk("reen_d2_kept", 32'(segment), 32'h08);

        // Randomized traffic, with one asynchronous reset mid-run.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 999) < 3) disp_en = ~disp_en;
            din_vld = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h00;
            din     = 24'($urandom);
            dp_in   = 6'($urandom);
            if ($urandom_range(0, 39) == 0) brightness = 3'($urandom);
            if ($urandom_range(0, 299) == 0) blank_mask = 6'($urandom) & 6'($urandom);
            if ($urandom_range(0, 299) == 0) blink_mask = 6'($urandom);
            if (i == 1000) begin
                #3;
                rst_n = 1'b0;
                #1;
                chk("async_rst_sel", 32'(seg_sel), 32'h7);
                chk("async_rst_seg", 32'(segment), 32'hFF);
                chk("async_rst_fd", 32'(frame_done), 32'h0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
